// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the opcode encoding, the controller state encoding and the fill
// value used for the result of undefined opcodes (13-15).
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Every bit of the result of an undefined opcode takes this value.
  localparam logic UNDEF_FILL = 1'b0;

endpackage

// File: rtl/seq_divider.sv
// Iterative signed divider: restoring division on operand magnitudes,
// one quotient bit per cycle, followed by one sign-correction cycle.
// Quotient truncates toward zero; remainder carries the sign of a.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              load a/b and begin (ignored while running)
//   a, b               dividend and divisor (two's complement, b != 0)
//   done               high during the sign-correction cycle, when
//                      quotient/remainder are valid
//   quotient, remainder signed results
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic             fixing;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // The dividend is shifted out of quo from the top while quotient bits
  // enter at the bottom. When the trial subtraction succeeds the difference
  // is below dvs, so its low WIDTH bits are exact.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - dvs;
    ge      = (shifted >= {1'b0, dvs});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      fixing  <= 1'b0;
      count   <= '0;
      dvs     <= '0;
      quo     <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (start && !running && !fixing) begin
      running <= 1'b1;
      count   <= '0;
      dvs     <= mag(b);
      quo     <= mag(a);
      rem     <= '0;
      neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r   <= a[WIDTH-1];
    end else if (running) begin
      rem   <= ge ? diff : shifted[WIDTH-1:0];
      quo   <= {quo[WIDTH-2:0], ge};
      count <= count + 1'b1;
      if (count == CW'(WIDTH - 1)) begin
        running <= 1'b0;
        fixing  <= 1'b1;
      end
    end else if (fixing) begin
      fixing <= 1'b0;
    end
  end

  // Most-negative / -1 yields a magnitude of 2^(W-1); negating it wraps
  // back to most-negative, which is the required result.
  assign done      = fixing;
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops, an iterative
// radix-2 Booth multiplier and an iterative divider (seq_divider).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request pulse, sampled only while idle
//   op, a, b      opcode and operands; b[SHW-1:0] is the shift amount
//   busy          high in the MUL, DIV and FIX states
//   done          one-cycle pulse in the DONE state
//   result        {HI, LO}, held until the next DONE
//   div_by_zero   set with done when DIV had b = 0
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    count;
  logic             last_step;
  logic             accept;
  logic             b_zero;
  logic             div_start;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             mq_m1;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mq_next;
  logic [2*WIDTH-1:0] product;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_lo;

  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign accept    = (state == IDLE) && start;
  assign b_zero    = (b == '0);
  assign div_start = accept && (op == OP_DIV) && !b_zero;
  assign last_step = (count == CW'(WIDTH - 1));
  assign busy      = (state == MUL) || (state == DIV) || (state == FIX);
  assign done      = (state == DONE);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Single-cycle operations, evaluated straight from the inputs so the
  // result can be captured on the accepting edge.
  always_comb begin
    sh     = b[SHW-1:0];
    alu_lo = {WIDTH{UNDEF_FILL}};
    case (op)
      OP_AND:  alu_lo = a & b;
      OP_OR:   alu_lo = a | b;
      OP_ADD:  alu_lo = a + b;
      OP_SUB:  alu_lo = a - b;
      OP_SHR:  alu_lo = a >> sh;
      OP_SHRA: alu_lo = $signed(a) >>> sh;
      OP_SHL:  alu_lo = a << sh;
      OP_ROR:  alu_lo = (a >> sh) | (a << (WIDTH - int'(sh)));
      OP_ROL:  alu_lo = (a << sh) | (a >> (WIDTH - int'(sh)));
      OP_NEG:  alu_lo = -a;
      OP_NOT:  alu_lo = ~a;
      default: alu_lo = {WIDTH{UNDEF_FILL}};
    endcase
  end

  // One Booth step: add/subtract the multiplicand per {Q0, Q-1}, then
  // arithmetic-shift {acc, mq, mq_m1} right by one. acc is one bit wider
  // than the operand so subtracting a most-negative multiplicand cannot
  // overflow.
  always_comb begin
    case ({mq[0], mq_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    acc_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mq_next  = {booth_sum[0], mq[WIDTH-1:1]};
    product  = {acc_next[WIDTH-1:0], mq_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            next_state = MUL;
          end else if (op == OP_DIV && !b_zero) begin
            next_state = DIV;
          end else begin
            next_state = DONE;
          end
        end
      end
      MUL:     if (last_step) next_state = DONE;
      DIV:     if (last_step) next_state = FIX;
      FIX:     if (div_done) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath. result/div_by_zero are loaded only on the edge that enters
  // DONE, so they change exactly when done rises and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      acc         <= '0;
      mq          <= '0;
      mq_m1       <= 1'b0;
      mcand       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            if (op == OP_MUL) begin
              acc   <= '0;
              mq    <= b;
              mq_m1 <= 1'b0;
              mcand <= {a[WIDTH-1], a};
            end else if (op == OP_DIV) begin
              if (b_zero) begin
                result      <= {a, {WIDTH{1'b1}}};
                div_by_zero <= 1'b1;
              end
            end else begin
              result      <= {{WIDTH{1'b0}}, alu_lo};
              div_by_zero <= 1'b0;
            end
          end
        end
        MUL: begin
          acc   <= acc_next;
          mq    <= mq_next;
          mq_m1 <= mq[0];
          count <= count + 1'b1;
          if (last_step) begin
            result      <= product;
            div_by_zero <= 1'b0;
          end
        end
        DIV: begin
          count <= count + 1'b1;
        end
        FIX: begin
          if (div_done) begin
            result      <= {div_rem, div_quo};
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32).
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     op = 4'd0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_by_zero;

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] result;
    logic        dbz;
    int          latency;
    int          start_cycle;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycle_cnt = 0;
  logic busy_seen = 1'b0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference model written bit by bit / with wide integer arithmetic.
  function automatic exp_t modelOp(input logic [3:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
    exp_t   e;
    int     sh;
    logic [31:0] lo;
    longint q;
    longint r;
    e.result = 64'd0;
    e.dbz = 1'b0;
    e.latency = 1;
    e.start_cycle = 0;
    sh = int'(y[4:0]);
    lo = 32'd0;
    case (o)
      OP_AND: lo = x & y;
      OP_OR:  lo = x | y;
      OP_ADD: lo = 32'(longint'(x) + longint'(y));
      OP_SUB: lo = 32'(longint'(x) - longint'(y));
      OP_NEG: lo = 32'(64'd0 - longint'(x));
      OP_NOT: lo = x ^ 32'hFFFF_FFFF;
      OP_SHR:  for (int i = 0; i < 32; i++) lo[i] = (i + sh < 32) ? x[i + sh] : 1'b0;
      OP_SHRA: for (int i = 0; i < 32; i++) lo[i] = (i + sh < 32) ? x[i + sh] : x[31];
      OP_SHL:  for (int i = 0; i < 32; i++) lo[i] = (i >= sh) ? x[i - sh] : 1'b0;
      OP_ROR:  for (int i = 0; i < 32; i++) lo[i] = x[(i + sh) % 32];
      OP_ROL:  for (int i = 0; i < 32; i++) lo[i] = x[(i - sh + 32) % 32];
      default: lo = 32'd0;
    endcase
    e.result = {32'd0, lo};
    if (o == OP_MUL) begin
      e.result = 64'(longint'($signed(x)) * longint'($signed(y)));
      e.latency = 33;
    end else if (o == OP_DIV) begin
      if (y == 32'd0) begin
        e.result = {x, 32'hFFFF_FFFF};
        e.dbz = 1'b1;
      end else begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        e.result = {r[31:0], q[31:0]};
        e.latency = 34;
      end
    end
    return e;
  endfunction

  // Scoreboard side: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_seen = 1'b1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.result);
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        checkOutput("latency", 64'(cycle_cnt - e.start_cycle), 64'(e.latency));
        checkOutput("busy_seen", 64'(busy_seen), 64'(e.latency > 1));
      end
    end
  end

  task automatic pushExpected(input logic [3:0] o, input logic [31:0] x,
                              input logic [31:0] y);
    exp_t e;
    e = modelOp(o, x, y);
    e.start_cycle = cycle_cnt;
    busy_seen = 1'b0;
    sb.push_back(e);
  endtask

  // One start pulse; inputs are scrambled right after the accepting edge.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x,
                               input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    pushExpected(o, x, y);
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_result"}, result, 64'd0);
    checkOutput({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    applyStimulus(OP_ADD, 32'd12, 32'd28);                 waitDrain(100);
    applyStimulus(OP_MUL, -32'sd3, 32'd4);                 waitDrain(100);
    applyStimulus(OP_MUL, -32'sd3, -32'sd4);               waitDrain(100);
    applyStimulus(OP_DIV, -32'sd7, 32'd2);                 waitDrain(100);
    applyStimulus(OP_DIV, 32'd24, 32'd0);                  waitDrain(100);
    applyStimulus(OP_ROR, 32'hFFFF_FFFC, 32'd1);           waitDrain(100);
    applyStimulus(OP_SHRA, 32'h8000_0000, 32'd33);         waitDrain(100);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   waitDrain(100);
    applyStimulus(OP_MUL, 32'h8000_0000, 32'h8000_0000);   waitDrain(100);
    applyStimulus(OP_SHL, 32'h1234_5678, 32'd0);           waitDrain(100);
    applyStimulus(OP_ROL, 32'h8000_0001, 32'd4);           waitDrain(100);
    applyStimulus(4'd14, 32'hDEAD_BEEF, 32'd5);            waitDrain(100);
    applyStimulus(OP_DIV, 32'd100, -32'sd7);               waitDrain(100);

    // Start while busy must be ignored and not queued
    applyStimulus(OP_MUL, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    waitDrain(100);
    repeat (3) @(negedge clk);

    // Start held into the DONE cycle must be ignored
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'd3; b = 32'd4;
    pushExpected(OP_ADD, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    waitDrain(10);
    repeat (3) @(negedge clk);

    // Random mix over all opcodes
    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      applyStimulus(ro, ra, rb);
      waitDrain(100);
    end

    // Reset abort during a multiply
    applyStimulus(OP_ADD, 32'd5, 32'd6);
    waitDrain(10);
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = -32'sd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_mul", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
    pushExpected(OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    start = 1'b0;
    waitDrain(10);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
